// File: rtl/qed_pkg.sv
// Shared definitions for the QED duplicate-instruction queue:
// controller state encoding, the reset NOP and the duplicable-class test.
package qed_pkg;

   typedef enum logic {
      ORIG = 1'b0,
      DUP  = 1'b1
   } qed_state_e;

   localparam logic [31:0] QED_NOP = 32'h0000_0013;

   function automatic logic is_dupable(input logic is_r, input logic is_i,
                                       input logic is_lw, input logic is_sw);
      return is_r | is_i | is_lw | is_sw;
   endfunction

endpackage

// File: rtl/qed_dup_fifo.sv
// Storage and pointers for captured duplicate instructions. The pointers carry
// one extra wrap bit so full and empty are distinguishable without a counter.
module qed_dup_fifo
   import qed_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        push,
   input  logic        pop,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        full,
   output logic        empty,
   output logic        last
);

   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic [31:0]  mem [DEPTH];
   logic         push_ok;
   logic         pop_ok;

   assign push_ok = push & ~full & ~flush;
   assign pop_ok  = pop & ~empty & ~flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Entries are never reset; the pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q[AW-1:0]] <= din;
   end

   assign dout  = mem[rd_ptr_q[AW-1:0]];
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign last  = ((wr_ptr_q - rd_ptr_q) == (AW+1)'(1));

endmodule

// File: rtl/qed_dup_queue.sv
// QED issue controller: passes originals while capturing their duplicates,
// then replays the duplicates in order when exec_dup is requested.
module qed_dup_queue
   import qed_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ena,
   input  logic        exec_dup,
   input  logic        stall,
   input  logic [31:0] ifu_instruction,
   input  logic        ifu_valid,
   input  logic        IS_R,
   input  logic        IS_I,
   input  logic        IS_LW,
   input  logic        IS_SW,
   input  logic [31:0] qed_dup_instruction,
   output logic [31:0] qic_instruction,
   output logic        qic_valid,
   output logic        qic_is_dup,
   output logic        fetch_hold,
   output logic        full,
   output logic        empty,
   output logic        dup_done
);

   qed_state_e   state_q, state_d;
   logic [31:0]  qic_instr_q, qic_instr_d;
   logic         qic_valid_q, qic_valid_d;
   logic         qic_is_dup_q, qic_is_dup_d;
   logic         dup_done_q, dup_done_d;

   logic         push, pop, flush;
   logic         dupable;
   logic         last;
   logic [31:0]  fifo_dout;

   assign dupable = is_dupable(IS_R, IS_I, IS_LW, IS_SW);

   qed_dup_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .din   (qed_dup_instruction),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty),
      .last  (last)
   );

   always_comb begin
      state_d      = state_q;
      qic_instr_d  = qic_instr_q;
      qic_valid_d  = qic_valid_q;
      qic_is_dup_d = qic_is_dup_q;
      dup_done_d   = dup_done_q;
      push         = 1'b0;
      pop          = 1'b0;
      flush        = 1'b0;
      fetch_hold   = 1'b0;

      if (!ena) begin
         if (!stall) begin
            state_d      = ORIG;
            flush        = 1'b1;
            qic_valid_d  = ifu_valid;
            qic_is_dup_d = 1'b0;
            dup_done_d   = 1'b0;
            if (ifu_valid) qic_instr_d = ifu_instruction;
         end
      end else if (state_q == ORIG) begin
         // A duplicable instruction with nowhere to put its twin must wait.
         fetch_hold = exec_dup | (ifu_valid & dupable & full);
         if (!stall) begin
            dup_done_d   = 1'b0;
            qic_is_dup_d = 1'b0;
            if (exec_dup) begin
               state_d     = DUP;
               qic_valid_d = 1'b0;
            end else if (ifu_valid && !(dupable && full)) begin
               qic_instr_d = ifu_instruction;
               qic_valid_d = 1'b1;
               push        = dupable;
            end else begin
               qic_valid_d = 1'b0;
            end
         end
      end else begin
         fetch_hold = 1'b1;
         if (!stall) begin
            dup_done_d = 1'b0;
            if (!empty) begin
               pop          = 1'b1;
               qic_instr_d  = fifo_dout;
               qic_valid_d  = 1'b1;
               qic_is_dup_d = 1'b1;
               if (last) begin
                  state_d    = ORIG;
                  dup_done_d = 1'b1;
               end
            end else begin
               state_d      = ORIG;
               qic_valid_d  = 1'b0;
               qic_is_dup_d = 1'b0;
               dup_done_d   = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ORIG;
         qic_instr_q  <= QED_NOP;
         qic_valid_q  <= 1'b0;
         qic_is_dup_q <= 1'b0;
         dup_done_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         qic_instr_q  <= qic_instr_d;
         qic_valid_q  <= qic_valid_d;
         qic_is_dup_q <= qic_is_dup_d;
         dup_done_q   <= dup_done_d;
      end
   end

   assign qic_instruction = qic_instr_q;
   assign qic_valid       = qic_valid_q;
   assign qic_is_dup      = qic_is_dup_q;
   assign dup_done        = dup_done_q;

endmodule

// File: tb/tb_qed_dup_queue.sv
// Directed bench for qed_dup_queue: issued instructions are predicted into a
// scoreboard and matched against qic_* whenever the block updates its output.
module tb_qed_dup_queue;

   typedef struct packed {
      logic [31:0] ins;
      logic        dup;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        ena;
   logic        exec_dup;
   logic        stall;
   logic [31:0] ifu_instruction;
   logic        ifu_valid;
   logic        IS_R, IS_I, IS_LW, IS_SW;
   logic [31:0] qed_dup_instruction;
   logic [31:0] qic_instruction;
   logic        qic_valid;
   logic        qic_is_dup;
   logic        fetch_hold;
   logic        full;
   logic        empty;
   logic        dup_done;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];
   logic [31:0] mdl[$];
   exp_t last_exp;

   qed_dup_queue dut (
      .clk                 (clk),
      .rst                 (rst),
      .ena                 (ena),
      .exec_dup            (exec_dup),
      .stall               (stall),
      .ifu_instruction     (ifu_instruction),
      .ifu_valid           (ifu_valid),
      .IS_R                (IS_R),
      .IS_I                (IS_I),
      .IS_LW               (IS_LW),
      .IS_SW               (IS_SW),
      .qed_dup_instruction (qed_dup_instruction),
      .qic_instruction     (qic_instruction),
      .qic_valid           (qic_valid),
      .qic_is_dup          (qic_is_dup),
      .fetch_hold          (fetch_hold),
      .full                (full),
      .empty               (empty),
      .dup_done            (dup_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock; if the block was free to update, match any issued instruction.
   task automatic step();
      logic s, r;
      exp_t e;
      s = stall;
      r = rst;
      @(posedge clk);
      #1;
      if (!s && !r && !rst && qic_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_issue", qic_instruction, 32'hxxxx_xxxx);
         end else begin
            e = sb.pop_front();
            last_exp = e;
            chk("qic_instruction", qic_instruction, e.ins);
            chk("qic_is_dup", {31'd0, qic_is_dup}, {31'd0, e.dup});
         end
      end
   endtask

   task automatic set_cls(input int c);
      IS_R  = (c == 1);
      IS_I  = (c == 2);
      IS_LW = (c == 3);
      IS_SW = (c == 4);
   endtask

   task automatic issue(input logic [31:0] ins, input logic [31:0] dv, input int c);
      ifu_instruction     = ins;
      qed_dup_instruction = dv;
      set_cls(c);
      ifu_valid           = 1'b1;
      sb.push_back('{ins: ins, dup: 1'b0});
      if (c != 0) mdl.push_back(dv);
      step();
   endtask

   task automatic idle();
      ifu_valid = 1'b0;
      set_cls(0);
   endtask

   task automatic do_replay(input int n, input bit hold, input int stall_at);
      exec_dup = 1'b1;
      #1;
      chk("hold_on_exec", {31'd0, fetch_hold}, 32'd1);
      foreach (mdl[k]) sb.push_back('{ins: mdl[k], dup: 1'b1});
      mdl.delete();
      step();
      chk("no_issue_on_entry", {31'd0, qic_valid}, 32'd0);
      chk("hold_in_dup", {31'd0, fetch_hold}, 32'd1);
      if (!hold || n < 2) exec_dup = 1'b0;
      if (n == 0) begin
         step();
         chk("empty_replay_valid", {31'd0, qic_valid}, 32'd0);
      end else begin
         for (int i = 0; i < n; i++) begin
            if (hold && i == n - 1) exec_dup = 1'b0;
            step();
            if (i < n - 1) chk("no_early_done", {31'd0, dup_done}, 32'd0);
            if (i == stall_at) begin
               stall = 1'b1;
               for (int k = 0; k < 3; k++) begin
                  step();
                  chk("stall_hold_ins", qic_instruction, last_exp.ins);
                  chk("stall_hold_valid", {31'd0, qic_valid}, 32'd1);
                  chk("stall_hold_dup", {31'd0, qic_is_dup}, 32'd1);
               end
               stall = 1'b0;
            end
         end
      end
      chk("dup_done", {31'd0, dup_done}, 32'd1);
      chk("empty_after_replay", {31'd0, empty}, 32'd1);
      chk("orig_after_replay", {31'd0, fetch_hold}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; ena = 1'b1; exec_dup = 1'b0; stall = 1'b0;
      ifu_instruction = '0; qed_dup_instruction = '0; ifu_valid = 1'b0;
      set_cls(0);
      last_exp = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_qic_instruction", qic_instruction, 32'h0000_0013);
      chk("rst_qic_valid", {31'd0, qic_valid}, 32'd0);
      chk("rst_qic_is_dup", {31'd0, qic_is_dup}, 32'd0);
      chk("rst_dup_done", {31'd0, dup_done}, 32'd0);
      chk("rst_empty", {31'd0, empty}, 32'd1);
      chk("rst_full", {31'd0, full}, 32'd0);
      chk("rst_fetch_hold", {31'd0, fetch_hold}, 32'd0);
      rst = 1'b0;
      step();

      // Test 1: four duplicable classes, exec_dup held through the replay
      issue(32'h0020_81B3, 32'hA000_000A, 1);
      issue(32'h0050_8113, 32'hB000_000B, 2);
      issue(32'h0041_2183, 32'hC000_000C, 3);
      issue(32'h0031_2223, 32'hD000_000D, 4);
      idle();
      step();
      chk("t1_not_empty", {31'd0, empty}, 32'd0);
      do_replay(4, 1'b1, -1);
      step();
      chk("t1_done_cleared", {31'd0, dup_done}, 32'd0);

      // Test 2: a branch passes but is not captured
      issue(32'h0011_0133, 32'h1111_0001, 1);
      issue(32'h0020_8463, 32'hDEAD_BEEF, 0);
      issue(32'h0071_0093, 32'h1111_0002, 2);
      idle();
      do_replay(2, 1'b0, -1);
      step();

      // Test 3: fill to capacity, then one more duplicable must wait
      for (int i = 0; i < 16; i++) begin
         issue(32'h1000_0033 + 32'(i << 7), 32'h3300_0000 + 32'(i), 1);
         if (i == 14) chk("t3_not_full_15", {31'd0, full}, 32'd0);
      end
      chk("t3_full_16", {31'd0, full}, 32'd1);
      ifu_instruction = 32'h1F00_0033; qed_dup_instruction = 32'h3300_0010;
      set_cls(1); ifu_valid = 1'b1;
      #1;
      chk("t3_fetch_hold_17", {31'd0, fetch_hold}, 32'd1);
      step();
      chk("t3_no_pass_when_full", {31'd0, qic_valid}, 32'd0);
      chk("t3_still_full", {31'd0, full}, 32'd1);
      do_replay(16, 1'b0, -1);
      sb.push_back('{ins: 32'h1F00_0033, dup: 1'b0});
      mdl.push_back(32'h3300_0010);
      step();
      chk("t3_17th_done_clear", {31'd0, dup_done}, 32'd0);
      chk("t3_17th_pushed", {31'd0, empty}, 32'd0);
      idle();
      do_replay(1, 1'b0, -1);
      step();

      // Test 4: replay request with nothing queued
      do_replay(0, 1'b0, -1);
      step();

      // Test 5: stall for three cycles after the second duplicate
      for (int i = 0; i < 5; i++) issue(32'h5000_0013 + 32'(i << 8), 32'h5500_0000 + 32'(i), 2);
      idle();
      do_replay(5, 1'b0, 1);
      step();

      // Test 6a: reset while replaying
      for (int i = 0; i < 5; i++) issue(32'h6000_0003 + 32'(i << 8), 32'h6600_0000 + 32'(i), 3);
      idle();
      exec_dup = 1'b1;
      sb.push_back('{ins: mdl[0], dup: 1'b1});
      mdl.delete();
      step();
      exec_dup = 1'b0;
      step();
      rst = 1'b1;
      #1;
      chk("t6_rst_empty", {31'd0, empty}, 32'd1);
      chk("t6_rst_valid", {31'd0, qic_valid}, 32'd0);
      chk("t6_rst_nop", qic_instruction, 32'h0000_0013);
      chk("t6_rst_hold", {31'd0, fetch_hold}, 32'd0);
      step();
      rst = 1'b0;
      step();

      // Test 6b: ena dropped mid-replay flushes back to ORIG
      for (int i = 0; i < 3; i++) issue(32'h7000_0023 + 32'(i << 8), 32'h7700_0000 + 32'(i), 4);
      idle();
      exec_dup = 1'b1;
      sb.push_back('{ins: mdl[0], dup: 1'b1});
      mdl.delete();
      step();
      exec_dup = 1'b0;
      step();
      ena = 1'b0;
      ifu_instruction = 32'h0000_0063; ifu_valid = 1'b1;
      sb.push_back('{ins: 32'h0000_0063, dup: 1'b0});
      #1;
      chk("t6_ena0_hold", {31'd0, fetch_hold}, 32'd0);
      step();
      chk("t6_ena0_empty", {31'd0, empty}, 32'd1);
      chk("t6_ena0_done", {31'd0, dup_done}, 32'd0);
      ena = 1'b1;
      idle();
      step();
      chk("t6_orig_hold", {31'd0, fetch_hold}, 32'd0);
      issue(32'h0000_0533, 32'h8800_0001, 1);
      idle();
      do_replay(1, 1'b0, -1);
      step();

      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/qed_dup_queue.md
QED_DUP_QUEUE -- requirements
Module: qed_dup_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of duplicate-instruction entries (power of 2, 4..64).
REQ-002 SHALL have parameter AW, default 4, pointer width, log2(DEPTH).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port ena, input, 1, QED mode enable.
REQ-006 SHALL have port exec_dup, input, 1, request to start the duplicate-issue phase.
REQ-007 SHALL have port stall, input, 1, pipeline stall; when high, no push, pop or output update occurs.
REQ-008 SHALL have port ifu_instruction, input, 32, original fetched instruction.
REQ-009 SHALL have port ifu_valid, input, 1, ifu_instruction is valid.
REQ-010 SHALL have ports IS_R, IS_I, IS_LW, IS_SW, input, 1 each, decoder class flags for ifu_instruction.
REQ-011 SHALL have port qed_dup_instruction, input, 32, register-remapped duplicate of ifu_instruction, same cycle.
REQ-012 SHALL have port qic_instruction, output, 32, instruction issued to the pipeline (registered).
REQ-013 SHALL have port qic_valid, output, 1, qic_instruction valid.
REQ-014 SHALL have port qic_is_dup, output, 1, qic_instruction is a duplicate.
REQ-015 SHALL have port fetch_hold, output, 1, tells the fetch unit to hold the current instruction.
REQ-016 SHALL have ports full and empty, output, 1 each, queue status; dup_done, output, 1, one-cycle pulse at end of replay.

Function
REQ-017 SHALL implement two states: ORIG (pass originals, capture duplicates) and DUP (replay duplicates).
REQ-018 In ORIG, when ena, ifu_valid and !stall, SHALL register ifu_instruction onto qic_instruction with qic_valid=1 and qic_is_dup=0 at the next edge (1-cycle latency).
REQ-019 In ORIG, an instruction is "duplicable" when IS_R|IS_I|IS_LW|IS_SW; a duplicable instruction SHALL push qed_dup_instruction onto the queue in the same cycle it is passed.
REQ-020 Non-duplicable instructions SHALL pass through without a push.
REQ-021 When full and a duplicable instruction arrives, there SHALL be no push and no pass; fetch_hold=1 combinationally and the instruction is held until exec_dup drains space.
REQ-022 ORIG->DUP SHALL occur on an edge where exec_dup=1 and ena=1 and !stall; no original is passed in that cycle and fetch_hold=1.
REQ-023 In DUP, fetch_hold SHALL be 1 and each !stall cycle SHALL pop the head and register it with qic_valid=1 and qic_is_dup=1, in FIFO order.
REQ-024 DUP->ORIG SHALL occur on the edge the last entry is popped; dup_done SHALL pulse for exactly the following cycle.
REQ-025 If the queue is empty on entry to DUP, the block SHALL return to ORIG after one cycle, issue nothing, and pulse dup_done.
REQ-026 When stall=1, all registers SHALL hold, including the qic_* outputs and the state.
REQ-027 Read and write pointers SHALL be AW+1 bits and wrap modulo 2*DEPTH; full = MSBs differ and low bits equal; empty = pointers equal.
REQ-028 Push and pop SHALL never occur in the same cycle, because the states are mutually exclusive.
REQ-029 When ena=0, the block SHALL force ORIG, clear both pointers (flush), pass ifu_instruction with qic_is_dup=0, drive fetch_hold=0 and assert no dup_done.
REQ-030 If exec_dup is held high while in DUP, it SHALL have no further effect.

Reset
REQ-031 On rst=1, asynchronously: state=ORIG, pointers=0, qic_instruction=32'h0000_0013 (NOP), qic_valid=0, qic_is_dup=0, dup_done=0; therefore empty=1, full=0 and fetch_hold=0.
REQ-032 Reset during DUP SHALL discard all entries; queue storage contents need no reset.

Structure
REQ-033 The package qed_pkg SHALL hold the state encoding (ORIG=1'b0, DUP=1'b1) and the NOP constant 32'h0000_0013.
REQ-034 Storage and pointers SHALL be a single sub-module, qed_dup_fifo (push, pop, din, dout, full, empty); control and the output register SHALL stay in qed_dup_queue.

Verification
REQ-035 Test 1: push ADD (IS_R), ADDI (IS_I), LW, SW with dup values A,B,C,D, then assert exec_dup -> qic shows the four originals, then A,B,C,D with qic_is_dup=1, then a dup_done pulse, then the state returns to ORIG.
REQ-036 Test 2: insert a BEQ (no flags) between duplicables -> BEQ passes, the queue count is unchanged, and the replay omits it.
REQ-037 Test 3: 17 duplicables with DEPTH=16 -> full=1 after 16, fetch_hold=1 on the 17th, and the 17th's duplicate is pushed only after the next replay.
REQ-038 Test 4: exec_dup with empty=1 -> no qic_valid for 1 cycle, then dup_done=1 and ORIG.
REQ-039 Test 5: stall=1 for 3 cycles mid-replay -> the outputs hold, and the replay resumes in order with no loss or duplication.
REQ-040 Test 6: rst pulse mid-DUP with 5 entries -> empty=1, qic_valid=0, qic_instruction=0x00000013; also ena=0 mid-DUP -> flush to ORIG.
